// File: rtl/pt_ring_pkg.sv
// Shared ring-link definitions: link FSM state encoding and default flit/credit sizing
// reused by the egress credit transmitter and the ingress TwoRegFifo instances.
package pt_ring_pkg;

  localparam int PT_WIDTH   = 8;
  localparam int PT_CRD_MAX = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } pt_state_e;

endpackage

// File: rtl/pt_crd_cnt.sv
// Up/down credit counter that saturates at MAX and never drops below zero.
// With ERR_EN set, an increment at MAX latches a sticky overflow flag until reset.
module pt_crd_cnt #(
  parameter int MAX    = 2,
  parameter bit ERR_EN = 1'b0,
  localparam int CW    = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;

  // a simultaneous return and consume cancel out
  always_comb begin
    w_nxt = r_cnt;
    case ({i_inc, i_dec})
      2'b10: begin
        if (r_cnt != MAX_C) w_nxt = r_cnt + CW'(1'b1);
        else                w_nxt = r_cnt;
      end
      2'b01: begin
        if (r_cnt != {CW{1'b0}}) w_nxt = r_cnt - CW'(1'b1);
        else                     w_nxt = r_cnt;
      end
      default: w_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= MAX_C;
    else        r_cnt <= w_nxt;
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_nxt;

  generate
    if (ERR_EN) begin : g_err
      logic r_err;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    r_err <= 1'b0;
        else if (i_inc && !i_dec && (r_cnt == MAX_C))  r_err <= 1'b1;
      end
      assign o_err = r_err;
    end else begin : g_no_err
      assign o_err = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pt_link_credit_chk.sv
// Simulation checks for the credit transmitter, compiled only with PT_LINK_CRD_CHK_EN:
// flags credit overflow and any send attempted with no credit left.
`ifdef PT_LINK_CRD_CHK_EN
module pt_link_credit_chk #(
  parameter int  CRD_MAX = 2,
  localparam int CW      = $clog2(CRD_MAX + 1)
) (
  input logic          clk,
  input logic          rst_n,
  input logic          i_send,
  input logic          i_crd_ret,
  input logic [CW-1:0] i_crd
);

  localparam logic [CW-1:0] CRD_FULL = CW'(CRD_MAX);

  a_no_crd_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_crd_ret && !i_send && (i_crd == CRD_FULL)))
    else $error("credit overflow: return received with counter already at %0d", CRD_MAX);

  a_no_send_without_crd: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_send && (i_crd == {CW{1'b0}})))
    else $error("send issued with zero credits");

endmodule
`endif

// File: rtl/pt_link_credit_tx.sv
// Ring-link transmitter: pops a show-ahead FIFO into a registered flit, gated by downstream credits.
// Optional macro PT_LINK_CRD_CHK_EN enables the sticky oCrdErr overflow flag and simulation checks.
module pt_link_credit_tx
  import pt_ring_pkg::*;
#(
  parameter int  WIDTH   = PT_WIDTH,
  parameter int  CRD_MAX = PT_CRD_MAX,
  localparam int CW      = $clog2(CRD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iEn,
  input  logic             iFifoEmpty,
  input  logic [WIDTH-1:0] iFifoRdDat,
  output logic             oFifoRdEn,
  output logic             oLinkVld,
  output logic [WIDTH-1:0] oLinkDat,
  input  logic             iLinkCrd,
  output logic [CW-1:0]    oCrd,
  output logic             oIdle,
  output logic             oCrdErr
);

`ifdef PT_LINK_CRD_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [CW-1:0] CRD_FULL = CW'(CRD_MAX);

  logic             w_send;
  logic [CW-1:0]    w_crd;
  logic [CW-1:0]    w_crd_nxt;
  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  pt_state_e        r_state;
  pt_state_e        w_state_nxt;

  // a credit returned this cycle is only usable next cycle; no pops while in reset
  assign w_send    = rst & iEn & ~iFifoEmpty & (w_crd != {CW{1'b0}});
  assign oFifoRdEn = w_send;

  pt_crd_cnt #(
    .MAX    (CRD_MAX),
    .ERR_EN (CHK_EN)
  ) u_crd_cnt (
    .clk       (clk),
    .rst_n     (rst),
    .i_inc     (iLinkCrd),
    .i_dec     (w_send),
    .o_cnt     (w_crd),
    .o_cnt_nxt (w_crd_nxt),
    .o_err     (oCrdErr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= {WIDTH{1'b0}};
    end else begin
      r_vld <= w_send;
      if (w_send) r_dat <= iFifoRdDat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // STALL is entered on the post-update credit count so a same-cycle return avoids it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_send) w_state_nxt = ST_SEND;
        else        w_state_nxt = ST_IDLE;
      end
      ST_SEND: begin
        if (w_send)                                                   w_state_nxt = ST_SEND;
        else if (iEn && !iFifoEmpty && (w_crd_nxt == {CW{1'b0}}))     w_state_nxt = ST_STALL;
        else                                                          w_state_nxt = ST_IDLE;
      end
      ST_STALL: begin
        if (w_send)                   w_state_nxt = ST_SEND;
        else if (!iEn || iFifoEmpty)  w_state_nxt = ST_IDLE;
        else                          w_state_nxt = ST_STALL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign oLinkVld = r_vld;
  assign oLinkDat = r_dat;
  assign oCrd     = w_crd;
  assign oIdle    = (r_state == ST_IDLE) & (w_crd == CRD_FULL) & ~r_vld & iFifoEmpty;

`ifdef PT_LINK_CRD_CHK_EN
  pt_link_credit_chk #(
    .CRD_MAX (CRD_MAX)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst),
    .i_send    (w_send),
    .i_crd_ret (iLinkCrd),
    .i_crd     (w_crd)
  );
`endif

endmodule

// File: tb/tb_pt_link_credit_tx.sv
// Scoreboard bench for pt_link_credit_tx (WIDTH=8, CRD_MAX=2): a queue-backed upstream FIFO,
// a credit/valid model checked every cycle, and per-scenario inline checks.
module tb_pt_link_credit_tx;

  localparam int CRD_MAX = 2;

  logic       clk = 1'b0;
  logic       rst, iEn, iFifoEmpty, iLinkCrd;
  logic [7:0] iFifoRdDat;
  logic       oFifoRdEn, oLinkVld, oIdle, oCrdErr;
  logic [7:0] oLinkDat;
  logic [1:0] oCrd;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] scb[$];
  logic [1:0] m_crd = 2'd2, m_crd_l = 2'd2;
  logic       m_vld = 1'b0, m_send_l = 1'b0, pop_pend = 1'b0, mon_en = 1'b0;
  logic       exp_err;

  pt_link_credit_tx dut (
    .clk        (clk),
    .rst        (rst),
    .iEn        (iEn),
    .iFifoEmpty (iFifoEmpty),
    .iFifoRdDat (iFifoRdDat),
    .oFifoRdEn  (oFifoRdEn),
    .oLinkVld   (oLinkVld),
    .oLinkDat   (oLinkDat),
    .iLinkCrd   (iLinkCrd),
    .oCrd       (oCrd),
    .oIdle      (oIdle),
    .oCrdErr    (oCrdErr)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    iFifoEmpty = (fifo_q.size() == 0);
    iFifoRdDat = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic model_reset();
    m_crd = 2'd2; m_crd_l = 2'd2; m_vld = 1'b0; m_send_l = 1'b0; pop_pend = 1'b0;
    scb.delete();
  endtask

  // Negedge: compare against model and scoreboard; posedge: advance model and FIFO.
  task automatic tick();
    logic       es;
    logic       ei;
    logic [7:0] ex;
    @(negedge clk);
    es = rst && iEn && !iFifoEmpty && (m_crd != 2'd0);
    ei = (m_crd == 2'd2) && !m_vld && iFifoEmpty;
    if (mon_en) begin
      checks++; if (oFifoRdEn !== es) begin errors++; $display("FAIL sb_rden: got %b expected %b at %0t", oFifoRdEn, es, $time); end
      checks++; if (oCrd !== m_crd) begin errors++; $display("FAIL sb_crd: got %0d expected %0d at %0t", oCrd, m_crd, $time); end
      checks++; if (oLinkVld !== m_vld) begin errors++; $display("FAIL sb_vld: got %b expected %b at %0t", oLinkVld, m_vld, $time); end
      checks++; if (oIdle !== ei) begin errors++; $display("FAIL sb_idle: got %b expected %b at %0t", oIdle, ei, $time); end
      if (m_vld) begin
        checks++;
        if (scb.size() == 0) begin
          errors++; $display("FAIL sb_dat: got %h expected nothing pending at %0t", oLinkDat, $time);
        end else begin
          ex = scb.pop_front();
          if (oLinkDat !== ex) begin errors++; $display("FAIL sb_dat: got %h expected %h at %0t", oLinkDat, ex, $time); end
        end
      end
    end
    pop_pend = oFifoRdEn;
    if (es) scb.push_back(iFifoRdDat);
    m_send_l = es;
    if (!rst)                                     m_crd_l = 2'd2;
    else if (es && !iLinkCrd)                     m_crd_l = m_crd - 2'd1;
    else if (!es && iLinkCrd && (m_crd != 2'd2))  m_crd_l = m_crd + 2'd1;
    else                                          m_crd_l = m_crd;
    @(posedge clk);
    if (rst) begin
      m_vld = m_send_l;
      m_crd = m_crd_l;
      if (pop_pend && (fifo_q.size() > 0)) fifo_q.delete(0);
    end
    pop_pend = 1'b0;
    #1;
    refresh();
  endtask

  task automatic test_reset();
    rst = 1'b0; iEn = 1'b0; iLinkCrd = 1'b0;
    refresh();
    tick(); tick();
    checks++; if (oLinkVld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b expected 0", oLinkVld); end
    checks++; if (oLinkDat !== 8'h00) begin errors++; $display("FAIL rst_dat: got %h expected 00", oLinkDat); end
    checks++; if (oCrd !== 2'd2) begin errors++; $display("FAIL rst_crd: got %0d expected 2", oCrd); end
    checks++; if (oCrdErr !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", oCrdErr); end
    checks++; if (oIdle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", oIdle); end
    fifo_q.push_back(8'hAA); iEn = 1'b1; refresh(); #1;
    checks++; if (oFifoRdEn !== 1'b0) begin errors++; $display("FAIL rst_rden: got %b expected 0", oFifoRdEn); end
    fifo_q.delete(); iEn = 1'b0; refresh();
    rst = 1'b1; mon_en = 1'b1;
    tick();
  endtask

  task automatic test_fill_stall();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
    iEn = 1'b1; refresh(); #1;
    checks++; if (oFifoRdEn !== 1'b1) begin errors++; $display("FAIL fill_rden0: got %b expected 1", oFifoRdEn); end
    tick(); #1;
    checks++; if (oLinkVld !== 1'b1 || oLinkDat !== 8'h01) begin errors++; $display("FAIL fill_f1: got vld=%b dat=%h expected vld=1 dat=01", oLinkVld, oLinkDat); end
    checks++; if (oCrd !== 2'd1 || oFifoRdEn !== 1'b1) begin errors++; $display("FAIL fill_c1: got crd=%0d rden=%b expected crd=1 rden=1", oCrd, oFifoRdEn); end
    tick(); #1;
    checks++; if (oLinkVld !== 1'b1 || oLinkDat !== 8'h02) begin errors++; $display("FAIL fill_f2: got vld=%b dat=%h expected vld=1 dat=02", oLinkVld, oLinkDat); end
    checks++; if (oCrd !== 2'd0 || oFifoRdEn !== 1'b0) begin errors++; $display("FAIL fill_c0: got crd=%0d rden=%b expected crd=0 rden=0", oCrd, oFifoRdEn); end
    tick(); #1;
    checks++; if (oLinkVld !== 1'b0 || oLinkDat !== 8'h02) begin errors++; $display("FAIL fill_stall: got vld=%b dat=%h expected vld=0 dat=02", oLinkVld, oLinkDat); end
    checks++; if (oIdle !== 1'b0 || oFifoRdEn !== 1'b0) begin errors++; $display("FAIL fill_held: got idle=%b rden=%b expected idle=0 rden=0", oIdle, oFifoRdEn); end
  endtask

  task automatic test_credit_return();
    iLinkCrd = 1'b1; #1;
    checks++; if (oFifoRdEn !== 1'b0) begin errors++; $display("FAIL crd_nobypass: got %b expected 0", oFifoRdEn); end
    tick(); iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd1 || oFifoRdEn !== 1'b1) begin errors++; $display("FAIL crd_use: got crd=%0d rden=%b expected crd=1 rden=1", oCrd, oFifoRdEn); end
    tick(); #1;
    checks++; if (oLinkVld !== 1'b1 || oLinkDat !== 8'h03 || oCrd !== 2'd0) begin errors++; $display("FAIL crd_f3: got vld=%b dat=%h crd=%0d expected vld=1 dat=03 crd=0", oLinkVld, oLinkDat, oCrd); end
    iLinkCrd = 1'b1; tick(); tick(); iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd2 || oIdle !== 1'b1) begin errors++; $display("FAIL crd_restore: got crd=%0d idle=%b expected crd=2 idle=1", oCrd, oIdle); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
    iLinkCrd = 1'b0; refresh(); #1;
    checks++; if (oFifoRdEn !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b expected 1", oFifoRdEn); end
    tick();
    for (int k = 1; k <= 8; k++) begin
      iLinkCrd = 1'b1; #1;
      checks++;
      if (oLinkVld !== 1'b1 || oLinkDat !== 8'(8'h10 + k - 1) || oCrd !== 2'd1) begin
        errors++; $display("FAIL b2b_%0d: got vld=%b dat=%h crd=%0d expected vld=1 dat=%h crd=1", k, oLinkVld, oLinkDat, oCrd, 8'(8'h10 + k - 1));
      end
      tick();
    end
    iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd2 || oLinkVld !== 1'b0) begin errors++; $display("FAIL b2b_end: got crd=%0d vld=%b expected crd=2 vld=0", oCrd, oLinkVld); end
  endtask

  task automatic test_overflow();
    iLinkCrd = 1'b1; tick(); tick(); iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd2) begin errors++; $display("FAIL ovf_sat: got %0d expected 2", oCrd); end
    checks++; if (oCrdErr !== exp_err) begin errors++; $display("FAIL ovf_err: got %b expected %b", oCrdErr, exp_err); end
    tick(); tick(); #1;
    checks++; if (oCrdErr !== exp_err) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", oCrdErr, exp_err); end
  endtask

  task automatic test_enable();
    fifo_q.push_back(8'h20); fifo_q.push_back(8'h21);
    iEn = 1'b0; refresh();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (oFifoRdEn !== 1'b0 || oLinkVld !== 1'b0 || oCrd !== 2'd2) begin errors++; $display("FAIL en_off%0d: got rden=%b vld=%b crd=%0d expected 0 0 2", i, oFifoRdEn, oLinkVld, oCrd); end
      tick();
    end
    iEn = 1'b1; #1;
    checks++; if (oFifoRdEn !== 1'b1) begin errors++; $display("FAIL en_resume: got %b expected 1", oFifoRdEn); end
    tick(); iEn = 1'b0; iLinkCrd = 1'b1; #1;
    checks++; if (oLinkVld !== 1'b1 || oLinkDat !== 8'h20 || oFifoRdEn !== 1'b0 || oCrd !== 2'd1) begin errors++; $display("FAIL en_drop: got vld=%b dat=%h rden=%b crd=%0d expected 1 20 0 1", oLinkVld, oLinkDat, oFifoRdEn, oCrd); end
    tick(); iEn = 1'b1; iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd2 || oLinkVld !== 1'b0 || oFifoRdEn !== 1'b1) begin errors++; $display("FAIL en_again: got crd=%0d vld=%b rden=%b expected 2 0 1", oCrd, oLinkVld, oFifoRdEn); end
    tick(); iLinkCrd = 1'b1; #1;
    checks++; if (oLinkVld !== 1'b1 || oLinkDat !== 8'h21 || oCrd !== 2'd1) begin errors++; $display("FAIL en_f21: got vld=%b dat=%h crd=%0d expected 1 21 1", oLinkVld, oLinkDat, oCrd); end
    tick(); iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd2) begin errors++; $display("FAIL en_crd: got %0d expected 2", oCrd); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h30 + i));
    refresh(); #1;
    checks++; if (oFifoRdEn !== 1'b1) begin errors++; $display("FAIL rm_start: got %b expected 1", oFifoRdEn); end
    tick(); tick(); #1;
    checks++; if (oCrd !== 2'd0 || oLinkVld !== 1'b1) begin errors++; $display("FAIL rm_pre: got crd=%0d vld=%b expected 0 1", oCrd, oLinkVld); end
    #1; rst = 1'b0; #1;
    checks++; if (oLinkVld !== 1'b0 || oCrd !== 2'd2 || oFifoRdEn !== 1'b0) begin errors++; $display("FAIL rm_async: got vld=%b crd=%0d rden=%b expected 0 2 0", oLinkVld, oCrd, oFifoRdEn); end
    checks++; if (oCrdErr !== 1'b0) begin errors++; $display("FAIL rm_err: got %b expected 0", oCrdErr); end
    fifo_q.delete(); refresh(); model_reset();
    tick(); rst = 1'b1; #1;
    checks++; if (oFifoRdEn !== 1'b0 || oCrd !== 2'd2) begin errors++; $display("FAIL rm_rel: got rden=%b crd=%0d expected 0 2", oFifoRdEn, oCrd); end
    tick(); fifo_q.push_back(8'h40); refresh(); #1;
    checks++; if (oFifoRdEn !== 1'b1) begin errors++; $display("FAIL rm_first: got %b expected 1", oFifoRdEn); end
    tick(); iLinkCrd = 1'b1; #1;
    checks++; if (oLinkVld !== 1'b1 || oLinkDat !== 8'h40 || oCrd !== 2'd1) begin errors++; $display("FAIL rm_f40: got vld=%b dat=%h crd=%0d expected 1 40 1", oLinkVld, oLinkDat, oCrd); end
    tick(); iLinkCrd = 1'b0; #1;
    checks++; if (oCrd !== 2'd2 || oIdle !== 1'b1) begin errors++; $display("FAIL rm_end: got crd=%0d idle=%b expected 2 1", oCrd, oIdle); end
    tick();
  endtask

  initial begin
`ifdef PT_LINK_CRD_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    test_reset();
    test_fill_stall();
    test_credit_return();
    test_back_to_back();
    test_overflow();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
